// File: rtl/core_mc_pkg.sv
// Shared types, constants and datapath helpers (alu, cmp, control, lsu) for the
// multi-cycle RV32I core.
package core_mc_pkg;

    localparam int CORESTATE_WIDTH = 3;

    typedef enum logic [CORESTATE_WIDTH-1:0] {
        CORESTATE_RESET = 3'd0,
        CORESTATE_FETCH = 3'd1,
        CORESTATE_EXEC  = 3'd2,
        CORESTATE_MEM   = 3'd3,
        CORESTATE_HALT  = 3'd4
    } core_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {WB_ALU, WB_LINK, WB_LOAD} wb_sel_t;

    typedef struct packed {
        logic        reg_write;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        a_pc;
        logic        a_zero;
        logic        b_imm;
        alu_op_t     alu_op;
        wb_sel_t     wb_sel;
        logic        is_illegal;
        logic [31:0] imm;
    } ctrl_t;

    function automatic alu_op_t alu_sel(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Illegal encodings decode to a side-effect-free NOP plus is_illegal.
    function automatic ctrl_t decode(input logic [31:0] ir);
        ctrl_t       c;
        logic [2:0]  f3;
        f3 = ir[14:12];
        c = '0;
        c.alu_op = ALU_ADD;
        c.wb_sel = WB_ALU;
        case (ir[6:0])
            OP_LUI: begin
                c.reg_write = 1'b1; c.a_zero = 1'b1; c.b_imm = 1'b1;
                c.imm = {ir[31:12], 12'd0};
            end
            OP_AUIPC: begin
                c.reg_write = 1'b1; c.a_pc = 1'b1; c.b_imm = 1'b1;
                c.imm = {ir[31:12], 12'd0};
            end
            OP_JAL: begin
                c.reg_write = 1'b1; c.is_jump = 1'b1; c.a_pc = 1'b1; c.b_imm = 1'b1;
                c.wb_sel = WB_LINK;
                c.imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    c.reg_write = 1'b1; c.is_jump = 1'b1; c.b_imm = 1'b1;
                    c.wb_sel = WB_LINK;
                    c.imm = {{20{ir[31]}}, ir[31:20]};
                end else begin
                    c.is_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (f3[2:1] != 2'b01) begin
                    c.is_branch = 1'b1; c.a_pc = 1'b1; c.b_imm = 1'b1;
                    c.imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
                end else begin
                    c.is_illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                if (f3 != 3'b011 && f3[2:1] != 2'b11) begin
                    c.reg_write = 1'b1; c.is_load = 1'b1; c.b_imm = 1'b1;
                    c.wb_sel = WB_LOAD;
                    c.imm = {{20{ir[31]}}, ir[31:20]};
                end else begin
                    c.is_illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3[2] == 1'b0 && f3[1:0] != 2'b11) begin
                    c.is_store = 1'b1; c.b_imm = 1'b1;
                    c.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                end else begin
                    c.is_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                c.reg_write = 1'b1; c.b_imm = 1'b1;
                c.alu_op = alu_sel(f3, (f3 == 3'b101) && ir[30]);
                c.imm = {{20{ir[31]}}, ir[31:20]};
            end
            OP_REG: begin
                c.reg_write = 1'b1;
                c.alu_op = alu_sel(f3, ir[30]);
            end
            OP_FENCE: ;
            OP_SYSTEM: c.is_illegal = (f3 == 3'b000) && ir[20];
            default: c.is_illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input alu_op_t op);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic cmp(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] funct3);
        logic t;
        case (funct3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) < $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a < b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] off, input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] v, input logic [1:0] size);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{v[7:0]}};
            2'b01:   d = {2{v[15:0]}};
            default: d = v;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] lsu_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] funct3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/core_mc_fsm.sv
// Sequencer for core_mc: state register, next-state logic and gating of bus
// requests, retire pulse and register-file write enable.
module core_mc_fsm
    import core_mc_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_ready,
    input  logic        mem_ready,
    input  logic        exec_mem,
    input  logic        exec_illegal,
    input  logic        mem_we,
    output core_state_t state,
    output logic        instr_req,
    output logic        mem_req,
    output logic        retire,
    output logic        wb_en,
    output logic        halted
);

    core_state_t state_next;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CORESTATE_RESET;
        else        state <= state_next;
    end

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        instr_req  = 1'b0;
        mem_req    = 1'b0;
        retire     = 1'b0;
        wb_en      = 1'b0;
        halted     = 1'b0;
        case (state)
            CORESTATE_RESET: state_next = CORESTATE_FETCH;
            CORESTATE_FETCH: begin
                instr_req = 1'b1;
                if (instr_ready) state_next = CORESTATE_EXEC;
            end
            CORESTATE_EXEC: begin
                if (exec_illegal && HALT_ON_ILLEGAL) begin
                    state_next = CORESTATE_HALT;
                end else if (exec_mem) begin
                    state_next = CORESTATE_MEM;
                end else begin
                    wb_en      = 1'b1;
                    retire     = 1'b1;
                    state_next = CORESTATE_FETCH;
                end
            end
            CORESTATE_MEM: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    wb_en      = !mem_we;
                    retire     = 1'b1;
                    state_next = CORESTATE_FETCH;
                end
            end
            CORESTATE_HALT: halted = 1'b1;
            default: state_next = CORESTATE_RESET;
        endcase
    end

endmodule

// File: rtl/core_mc.sv
// Multi-cycle RV32I core with valid/ready instruction and data bus masters.
// Datapath lives here; sequencing is in core_mc_fsm.
module core_mc
    import core_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_instr_req,
    output logic [29:0] o_instr_addr,
    input  logic        i_instr_ready,
    input  logic [31:0] i_instr_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_data,
    output logic        o_retire,
    output logic        o_halted
);

    core_state_t state;
    logic        fsm_instr_req, fsm_mem_req, fsm_retire, fsm_wb_en, fsm_halted;

    logic [29:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] rf [1:31];

    ctrl_t       ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_res, link_addr, load_val, wb_data;
    logic [29:0] pc_inc, pc_next;
    logic        exec_mem, taken, rf_we;

    logic        mem_we_q;
    logic [29:0] mem_addr_q;
    logic [1:0]  mem_off_q;
    logic [31:0] mem_data_q;
    logic [3:0]  mem_mask_q;

    assign ctrl     = decode(ir_q);
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign rd       = ir_q[11:7];
    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    assign exec_mem = ctrl.is_load | ctrl.is_store;

    // Branch/JAL targets use the ALU with pc as operand A; cmp decides the branch.
    assign alu_a     = ctrl.a_zero ? 32'd0 : (ctrl.a_pc ? {pc_q, 2'b00} : rs1_val);
    assign alu_b     = ctrl.b_imm ? ctrl.imm : rs2_val;
    assign alu_res   = alu(alu_a, alu_b, ctrl.alu_op);
    assign taken     = ctrl.is_jump | (ctrl.is_branch & cmp(rs1_val, rs2_val, ir_q[14:12]));
    assign pc_inc    = pc_q + 30'd1;
    assign pc_next   = taken ? alu_res[31:2] : pc_inc;
    assign link_addr = {pc_inc, 2'b00};
    assign load_val  = lsu_load(i_mem_data, mem_off_q, ir_q[14:12]);

    always_comb begin
        case (ctrl.wb_sel)
            WB_LINK: wb_data = link_addr;
            WB_LOAD: wb_data = load_val;
            default: wb_data = alu_res;
        endcase
    end

    assign rf_we = fsm_wb_en & ctrl.reg_write & (rd != 5'd0);

    core_mc_fsm #(
        .HALT_ON_ILLEGAL (HALT_ON_ILLEGAL)
    ) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_ready  (i_instr_ready),
        .mem_ready    (i_mem_ready),
        .exec_mem     (exec_mem),
        .exec_illegal (ctrl.is_illegal),
        .mem_we       (mem_we_q),
        .state        (state),
        .instr_req    (fsm_instr_req),
        .mem_req      (fsm_mem_req),
        .retire       (fsm_retire),
        .wb_en        (fsm_wb_en),
        .halted       (fsm_halted)
    );

    // ir only changes on an accepted fetch, so decode stays stable through MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC[31:2];
            ir_q <= NOP_INSTR;
        end else begin
            if (fsm_instr_req && i_instr_ready) ir_q <= i_instr_data;
            if (fsm_retire) pc_q <= (state == CORESTATE_MEM) ? pc_inc : pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_off_q  <= '0;
            mem_data_q <= '0;
            mem_mask_q <= '0;
        end else if (state == CORESTATE_EXEC && exec_mem) begin
            mem_we_q   <= ctrl.is_store;
            mem_addr_q <= alu_res[31:2];
            mem_off_q  <= alu_res[1:0];
            mem_data_q <= store_data(rs2_val, ir_q[13:12]);
            mem_mask_q <= ctrl.is_store ? store_mask(alu_res[1:0], ir_q[13:12]) : 4'hF;
        end
    end

    // NOTE: the register file is a plain memory with no reset; software
    // initialises it and a reset port would block RAM mapping.
    always_ff @(posedge clk) begin
        if (rf_we) rf[rd] <= wb_data;
    end

    assign o_instr_req  = fsm_instr_req;
    assign o_instr_addr = pc_q;
    assign o_mem_req    = fsm_mem_req;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_data   = mem_data_q;
    assign o_mem_mask   = mem_mask_q;
    assign o_retire     = fsm_retire;
    assign o_halted     = fsm_halted;

endmodule

// File: tb/tb_core_mc.sv
// Directed bench for core_mc: bus responders with programmable wait states,
// a bus/retire monitor, and hand-computed expectations per program.
module tb_core_mc;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        rst_n;
    logic        instr_req, instr_ready, mem_req, mem_we, mem_ready, retire, halted;
    logic [29:0] instr_addr, mem_addr;
    logic [31:0] instr_data, mem_data, mem_rdata;
    logic [3:0]  mem_mask;

    logic        rst2_n;
    logic        r2_instr_req, r2_instr_ready, r2_mem_req, r2_mem_we, r2_mem_ready;
    logic        r2_retire, r2_halted;
    logic [29:0] r2_instr_addr, r2_mem_addr;
    logic [31:0] r2_instr_data, r2_mem_data, r2_mem_rdata;
    logic [3:0]  r2_mem_mask;

    core_mc dut (
        .clk (clk), .rst_n (rst_n),
        .o_instr_req (instr_req), .o_instr_addr (instr_addr),
        .i_instr_ready (instr_ready), .i_instr_data (instr_data),
        .o_mem_req (mem_req), .o_mem_we (mem_we), .o_mem_addr (mem_addr),
        .o_mem_data (mem_data), .o_mem_mask (mem_mask),
        .i_mem_ready (mem_ready), .i_mem_data (mem_rdata),
        .o_retire (retire), .o_halted (halted)
    );

    core_mc #(.RESET_PC (32'h0000_0100), .HALT_ON_ILLEGAL (1'b1)) dut_rv (
        .clk (clk), .rst_n (rst2_n),
        .o_instr_req (r2_instr_req), .o_instr_addr (r2_instr_addr),
        .i_instr_ready (r2_instr_ready), .i_instr_data (r2_instr_data),
        .o_mem_req (r2_mem_req), .o_mem_we (r2_mem_we), .o_mem_addr (r2_mem_addr),
        .o_mem_data (r2_mem_data), .o_mem_mask (r2_mem_mask),
        .i_mem_ready (r2_mem_ready), .i_mem_data (r2_mem_rdata),
        .o_retire (r2_retire), .o_halted (r2_halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] im, a, f, d;
        im = imm; a = rs1; f = f3; d = rd;
        return {im[11:0], a[4:0], f[2:0], d[4:0], op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im, a, b, f;
        im = imm; a = rs1; b = rs2; f = f3;
        return {im[11:5], b[4:0], a[4:0], f[2:0], im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] im, a, b, f;
        im = imm; a = rs1; b = rs2; f = f3;
        return {im[12], im[10:5], b[4:0], a[4:0], f[2:0], im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] im, d;
        im = imm; d = rd;
        return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'b1101111};
    endfunction

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:15];
    int fetch_wait = 0;
    int mem_wait   = 0;

    // Bus responders: wait-state counters, ready/data driven on the falling edge.
    initial begin
        int iw, mw;
        iw = 0; mw = 0;
        instr_ready = 1'b0; instr_data = '0; mem_ready = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !instr_req) begin
                instr_ready = 1'b0; iw = 0;
            end else if (iw < fetch_wait) begin
                instr_ready = 1'b0; iw++;
            end else begin
                instr_ready = 1'b1; instr_data = imem[instr_addr[5:0]]; iw = 0;
            end
            if (!rst_n || !mem_req) begin
                mem_ready = 1'b0; mw = 0;
            end else if (mw < mem_wait) begin
                mem_ready = 1'b0; mw++;
            end else begin
                mem_ready = 1'b1; mw = 0;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_mask[b]) dmem[mem_addr[3:0]][8*b +: 8] = mem_data[8*b +: 8];
                end else begin
                    mem_rdata = dmem[mem_addr[3:0]];
                end
            end
        end
    end

    int          cyc = 0;
    int          unstable_cnt = 0, both_cnt = 0, mem_ret_cnt = 0;
    int          fetch_q[$], fetch_len_q[$], retire_q[$], mem_len_q[$];
    logic        we_q[$];
    logic [3:0]  mask_q[$];
    logic [29:0] maddr_q[$];
    logic [31:0] mdata_q[$];

    // Monitor samples mid-cycle, after the responder has settled its inputs.
    initial begin
        int          ilen, mlen;
        logic [29:0] iaddr0;
        logic [66:0] mbus0;
        ilen = 0; mlen = 0; iaddr0 = '0; mbus0 = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                ilen = 0; mlen = 0;
            end else begin
                cyc++;
                if (retire) begin
                    retire_q.push_back(cyc);
                    if (mem_req && mem_ready) mem_ret_cnt++;
                end
                if (instr_req && mem_req) both_cnt++;
                if (instr_req) begin
                    if (ilen == 0) iaddr0 = instr_addr;
                    else if (instr_addr !== iaddr0) unstable_cnt++;
                    ilen++;
                    if (instr_ready) begin
                        fetch_q.push_back(int'(instr_addr));
                        fetch_len_q.push_back(ilen);
                        ilen = 0;
                    end
                end
                if (mem_req) begin
                    if (mlen == 0) mbus0 = {mem_we, mem_addr, mem_data, mem_mask};
                    else if ({mem_we, mem_addr, mem_data, mem_mask} !== mbus0) unstable_cnt++;
                    mlen++;
                    if (mem_ready) begin
                        mem_len_q.push_back(mlen);
                        we_q.push_back(mem_we);
                        mask_q.push_back(mem_mask);
                        maddr_q.push_back(mem_addr);
                        mdata_q.push_back(mem_data);
                        mlen = 0;
                    end
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) imem[i] = EBREAK;
        for (int i = 0; i < 16; i++) dmem[i] = '0;
    endtask

    task automatic do_reset(input int fw, input int mw, input bit chk);
        @(negedge clk);
        rst_n = 1'b0;
        fetch_wait = fw;
        mem_wait   = mw;
        repeat (2) @(negedge clk);
        #2;
        if (chk) begin
            check("rst_instr_req", instr_req, 0);
            check("rst_instr_addr", instr_addr, 0);
            check("rst_mem_req", mem_req, 0);
            check("rst_mem_mask", mem_mask, 0);
            check("rst_retire_halted", {retire, halted}, 0);
        end
        fetch_q.delete(); fetch_len_q.delete(); retire_q.delete(); mem_len_q.delete();
        we_q.delete(); mask_q.delete(); maddr_q.delete(); mdata_q.delete();
        unstable_cnt = 0; both_cnt = 0; mem_ret_cnt = 0; cyc = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        check({tag, "_halted"}, halted, 1);
    endtask

    initial begin
        int          n, req_seen;
        logic [31:0] d;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        r2_instr_ready = 1'b1;
        r2_instr_data  = 32'h0000_2023;   // SW x0,0(x0)
        r2_mem_ready   = 1'b0;
        r2_mem_rdata   = '0;

        // ALU chain, zero-wait buses; results observed through stores.
        clear_mem();
        imem[0] = enc_i(5, 0, 0, 1, 7'b0010011);
        imem[1] = enc_i(-3, 1, 0, 2, 7'b0010011);
        imem[2] = enc_s(0, 1, 0, 2);
        imem[3] = enc_s(4, 2, 0, 2);
        do_reset(0, 0, 1'b1);
        run_until_halt("t1", 200);
        check("t1_fetch0", fetch_q[0], 0);
        check("t1_fetch1", fetch_q[1], 1);
        check("t1_fetch2", fetch_q[2], 2);
        check("t1_retire_gap", retire_q[1] - retire_q[0], 2);
        check("t1_retire_cnt", retire_q.size(), 4);
        check("t1_x1", dmem[0], 5);
        check("t1_x2", dmem[1], 2);
        check("t1_sw_mask", mask_q[0], 4'hF);
        check("t1_both_active", both_cnt, 0);
        req_seen = 0;
        repeat (5) begin
            @(negedge clk);
            #2;
            if (instr_req || mem_req) req_seen++;
        end
        check("t1_halt_quiet", req_seen, 0);

        // Same program, three fetch wait cycles per instruction.
        clear_mem();
        imem[0] = enc_i(5, 0, 0, 1, 7'b0010011);
        imem[1] = enc_i(-3, 1, 0, 2, 7'b0010011);
        imem[2] = enc_s(0, 1, 0, 2);
        imem[3] = enc_s(4, 2, 0, 2);
        do_reset(3, 0, 1'b0);
        run_until_halt("t2", 300);
        check("t2_fetch_hold", fetch_len_q[0], 4);
        check("t2_stable", unstable_cnt, 0);
        check("t2_retire_gap", retire_q[1] - retire_q[0], 5);
        check("t2_x1", dmem[0], 5);
        check("t2_x2", dmem[1], 2);

        // Byte store into lane 1 with two memory wait cycles.
        clear_mem();
        imem[0] = enc_i(32'hAB, 0, 0, 2, 7'b0010011);
        imem[1] = enc_s(1, 2, 0, 0);
        do_reset(0, 2, 1'b0);
        run_until_halt("t3", 200);
        check("t3_we", we_q[0], 1);
        check("t3_addr", maddr_q[0], 0);
        check("t3_mask", mask_q[0], 4'b0010);
        d = mdata_q[0];
        check("t3_lane1", d[15:8], 8'hAB);
        check("t3_hold", mem_len_q[0], 3);
        check("t3_stable", unstable_cnt, 0);
        check("t3_dmem", dmem[0], 32'h0000_AB00);

        // Signed and unsigned byte loads with one memory wait cycle.
        clear_mem();
        dmem[0] = 32'h0080_0000;
        imem[0] = enc_i(2, 0, 0, 3, 7'b0000011);
        imem[1] = enc_s(4, 3, 0, 2);
        imem[2] = enc_i(2, 0, 4, 4, 7'b0000011);
        imem[3] = enc_s(8, 4, 0, 2);
        do_reset(0, 1, 1'b0);
        run_until_halt("t4", 300);
        check("t4_load_we", we_q[0], 0);
        check("t4_load_mask", mask_q[0], 4'hF);
        check("t4_lb", dmem[1], 32'hFFFF_FF80);
        check("t4_lbu", dmem[2], 32'h0000_0080);
        check("t4_mem_retires", mem_ret_cnt, 4);
        check("t4_retire_gap", retire_q[1] - retire_q[0], 4);

        // JAL to word 4, BEQ to word 6, JAL back to word 2 storing the link.
        clear_mem();
        imem[0] = enc_j(16, 0);
        imem[4] = enc_b(8, 0, 0, 0);
        imem[6] = enc_j(-16, 1);
        imem[2] = enc_s(0, 1, 0, 2);
        do_reset(0, 0, 1'b0);
        run_until_halt("t5", 200);
        check("t5_fetch_jal", fetch_q[1], 4);
        check("t5_fetch_beq", fetch_q[2], 6);
        check("t5_fetch_back", fetch_q[3], 2);
        check("t5_fetch_next", fetch_q[4], 3);
        check("t5_link", dmem[0], 28);

        // All-zero word is undecoded: halt with no retire and no further requests.
        clear_mem();
        imem[0] = 32'h0000_0000;
        do_reset(0, 0, 1'b0);
        run_until_halt("t6", 50);
        check("t6_retire_cnt", retire_q.size(), 0);
        req_seen = 0;
        repeat (5) begin
            @(negedge clk);
            #2;
            if (instr_req || mem_req) req_seen++;
        end
        check("t6_quiet", req_seen, 0);
        check("t6_fetch_cnt", fetch_q.size(), 1);

        // RESET_PC=0x100 instance: reset values, then reset during a stalled store.
        #2;
        check("t7_rst_addr", r2_instr_addr, 30'h40);
        check("t7_rst_req", {r2_instr_req, r2_mem_req, r2_halted}, 0);
        @(negedge clk);
        rst2_n = 1'b1;
        n = 0;
        while (!r2_mem_req && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("t7_mem_req_up", r2_mem_req, 1);
        check("t7_mem_we", r2_mem_we, 1);
        #1;
        rst2_n = 1'b0;
        #1;
        check("t7_mem_req_drop", r2_mem_req, 0);
        check("t7_no_retire", r2_retire, 0);
        check("t7_addr_reset", r2_instr_addr, 30'h40);
        @(negedge clk);
        rst2_n = 1'b1;
        @(posedge clk);
        #1;
        check("t7_refetch_req", r2_instr_req, 1);
        check("t7_refetch_addr", r2_instr_addr, 30'h40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_mc.md
Name: core_mc

Overview:
- Multi-cycle RV32I core; successor to the single-cycle core.
- Instruction and data ports become valid/ready bus masters, so memories and peripherals may insert wait states.
- Reset vector is parametrised; halting on illegal/EBREAK is optional.
- Reuses existing alu, cmp, control, reg_file and lsu blocks. Sits between the instruction ROM/bus and the data RAM/MMIO interconnect.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch; bits [1:0] must be 0.
- HALT_ON_ILLEGAL, 1, 1 = enter HALT on EBREAK or undecoded opcode; 0 = treat as NOP.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- o_instr_req  out  1  fetch request valid
- o_instr_addr  out  30  word address of fetch
- i_instr_ready  in  1  fetch complete; i_instr_data valid this cycle
- i_instr_data  in  32  fetched instruction
- o_mem_req  out  1  data request valid
- o_mem_we  out  1  1 = store, 0 = load
- o_mem_addr  out  30  word address
- o_mem_data  out  32  store data, lane-aligned
- o_mem_mask  out  4  byte-lane enables (stores); 4'hF on loads
- i_mem_ready  in  1  data transfer complete
- i_mem_data  in  32  load data, valid when i_mem_ready=1
- o_retire  out  1  one-cycle pulse when an instruction completes
- o_halted  out  1  core is in HALT

Behaviour:
- Reset is asynchronous, active-low: rst_n, clock clk.
- Reset values: state=RESET, pc=RESET_PC[31:2], ir=32'h0000_0013 (NOP). All outputs are 0, except o_instr_addr = RESET_PC[31:2].
- Reset mid-transaction: requests drop in the same instant, with no completion and no register write.
- RESET -> FETCH unconditionally on the first clock after rst_n deasserts.
- FETCH:
  - o_instr_req=1 and o_instr_addr=pc, held stable until i_instr_ready=1 is sampled.
  - ready may be 1 in the first request cycle (zero wait).
  - On ready: ir <= i_instr_data, go to EXEC.
- EXEC:
  - Decode ir through control; compute alu/cmp.
  - Non-memory instruction: write rd (wb_en gated by state), pc <= pc_next (taken: alu_res[31:2]; else pc+1), o_retire=1, go to FETCH.
  - Load/store: latch address, store data and mask into registers, go to MEM.
  - Illegal/EBREAK with HALT_ON_ILLEGAL=1: go to HALT, no retire, pc unchanged.
- MEM:
  - o_mem_req=1; we/addr/data/mask come from the latched registers and are stable until i_mem_ready=1.
  - On ready: a load writes rd from lsu-extracted i_mem_data (LB/LH/LBU/LHU/LW extension). Then pc <= pc+1, o_retire=1, go to FETCH.
- HALT: all requests 0, o_halted=1. Exit only via reset.
- CPI at zero wait: 2 for ALU/branch/jump, 3 for load/store. Each bus wait cycle adds 1.
- Writes to x0 are discarded; JAL/JALR write pc+4.
- Misaligned branch/jump targets are truncated to a word address.
- Misaligned accesses: address truncated, lanes per the lsu mask; no trap.
- Register-file writes occur only on the completing cycle. ir and latched operands must not change while a request is pending.
- One outstanding request per port; the ports are never active simultaneously.

Decomposition:
- Shared package/header core_mc.vh holds the state encoding:
  - CORESTATE_RESET / FETCH / EXEC / MEM / HALT, with CORESTATE_WIDTH=3
  - NOP_INSTR constant
- Existing alu.vh, cmp.vh and control.vh are reused unchanged.
- control gains one output, o_is_illegal.
- Natural sub-module: core_mc_fsm (state register, next-state logic, request/retire/wb-enable gating). The datapath stays in core_mc.

Test Plan:
- ADDI x1,x0,5; ADDI x2,x1,-3; zero-wait buses -> x1=5, x2=2; o_retire pulses every 2 cycles; pc advances 0,1,2.
- Fetch wait of 3 cycles on every instruction -> o_instr_addr and o_instr_req held constant for 4 cycles; retire every 5 cycles; register results unchanged.
- SB x2,1(x0) with x2=0xAB, mem wait 2 -> o_mem_we=1, o_mem_addr=0, o_mem_mask=4'b0010, o_mem_data[15:8]=0xAB, stable for 3 cycles.
- LB x3,2(x0) with i_mem_data=0x0080_0000 after 1 wait -> x3=0xFFFF_FF80; retire on the ready cycle.
- BEQ x0,x0,+8 at pc=word 4 -> next o_instr_addr=6; JAL x1,-16 at word 6 -> x1=28, next fetch word 2.
- Opcode 0x0000_0000 with HALT_ON_ILLEGAL=1 -> o_halted=1, no further requests. Separately, asserting rst_n=0 during a MEM wait drops o_mem_req immediately, and refetch starts at RESET_PC=0x100 (o_instr_addr=0x40).
